// File: rtl/fp12_div_sequencer_pkg.sv
// fp12 format constants, sequencer state encoding and small fp12 helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// fp12 layout: sign[11], exponent[10:6] (bias 15), mantissa[5:0].
// A value is zero when both the exponent and the mantissa are zero; the sign
// bit is ignored, so 12'h800 also counts as zero.
package fp12_div_sequencer_pkg;

  localparam int FP12_W        = 12;
  localparam int FP12_SIGN_POS = 11;
  localparam int FP12_EXP_LSB  = 6;
  localparam int FP12_EXP_W    = 5;
  localparam int FP12_MANT_LSB = 0;
  localparam int FP12_MANT_W   = 6;
  localparam int FP12_BIAS     = 15;

  localparam logic [FP12_EXP_W-1:0] FP12_EXP_INF = 5'b11111;
  localparam logic [FP12_W-1:0]     FP12_ZERO    = 12'h000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_OUTPUT = 2'd3
  } seq_state_t;

  // One queue entry: dividend in the upper half, divisor in the lower half.
  typedef struct packed {
    logic [FP12_W-1:0] a;
    logic [FP12_W-1:0] b;
  } fp12_pair_t;

  function automatic logic fp12_is_zero(input logic [FP12_W-1:0] v);
    return (v[FP12_EXP_LSB +: FP12_EXP_W] == '0) &&
           (v[FP12_MANT_LSB +: FP12_MANT_W] == '0);
  endfunction

  // Signed infinity with the quotient's sign, returned for a zero divisor.
  function automatic logic [FP12_W-1:0] fp12_div0_result(input logic [FP12_W-1:0] a,
                                                         input logic [FP12_W-1:0] b);
    logic [FP12_W-1:0] r;
    r = FP12_ZERO;
    r[FP12_SIGN_POS] = a[FP12_SIGN_POS] ^ b[FP12_SIGN_POS];
    r[FP12_EXP_LSB +: FP12_EXP_W] = FP12_EXP_INF;
    return r;
  endfunction

  function automatic int fp12_exp_unbiased(input logic [FP12_W-1:0] v);
    return int'(v[FP12_EXP_LSB +: FP12_EXP_W]) - FP12_BIAS;
  endfunction

endpackage

// File: rtl/fp12_pair_fifo.sv
// Generic synchronous FIFO holding fp12 operand pairs, first-word fall-through.
// Latency: a push is visible on rd_vld/rd_dat the cycle after the write edge.
// Backpressure: wr_rdy drops when full; rd_vld low when empty; push+pop same edge both apply.
//
// Ports:
//   clk, rst_n      clock, async active-low reset (clears pointers and count)
//   wr_vld/wr_rdy   write handshake, wr_dat = entry to store
//   rd_vld/rd_rdy   read handshake, rd_dat = oldest entry (valid while rd_vld)
module fp12_pair_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_vld,
  output logic              wr_rdy,
  input  logic [DATA_W-1:0] wr_dat,
  output logic              rd_vld,
  input  logic              rd_rdy,
  output logic [DATA_W-1:0] rd_dat
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              push;
  logic              pop;

  assign wr_rdy = (count != FULL_CNT);
  assign rd_vld = (count != '0);
  assign push   = wr_vld && wr_rdy;
  assign pop    = rd_rdy && rd_vld;
  assign rd_dat = mem[rd_ptr];

  // Depth is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: nothing reads an entry before it is written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

endmodule

// File: rtl/fp12_div_sequencer.sv
// Queues fp12 operand pairs and sequences them one at a time through an external divider.
// Latency: push->div_start 2 edges (div0 push->out_valid 2 edges); div_done->out_valid 1 edge.
// Backpressure: in_ready = queue not full; result held on out_* until out_ready.
//
// Ports:
//   clk, rst_n                 rising-edge clock, async active-low reset
//   in_valid/in_ready          operand push handshake; in_a dividend, in_b divisor
//   div_a, div_b, div_start    request to the divider (div_start is a one-cycle pulse)
//   div_result, div_done       divider answer, only looked at while waiting
//   out_valid/out_ready        result handshake; out_data plus out_div0/out_timeout flags
module fp12_div_sequencer
  import fp12_div_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 63
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP12_W-1:0] in_a,
  input  logic [FP12_W-1:0] in_b,
  output logic [FP12_W-1:0] div_a,
  output logic [FP12_W-1:0] div_b,
  output logic              div_start,
  input  logic [FP12_W-1:0] div_result,
  input  logic              div_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FP12_W-1:0] out_data,
  output logic              out_div0,
  output logic              out_timeout
);

  localparam int PAIR_W = $bits(fp12_pair_t);
  localparam int CNT_W  = $clog2(TIMEOUT_CYC + 1);
  // The counter holds the number of WAIT cycles already completed, so the
  // cycle on which it equals this value is the last one allowed.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  seq_state_t       state;
  logic [CNT_W-1:0] wait_cnt;

  fp12_pair_t  q_wr_dat;
  logic [PAIR_W-1:0] q_rd_dat;
  fp12_pair_t  head;
  logic        q_rd_vld;
  logic        q_rd_rdy;
  logic        head_vld_q;
  logic        head_take;

  assign q_wr_dat = '{a: in_a, b: in_b};
  assign head     = fp12_pair_t'(q_rd_dat);

  fp12_pair_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (PAIR_W)
  ) u_pair_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (in_valid),
    .wr_rdy (in_ready),
    .wr_dat (q_wr_dat),
    .rd_vld (q_rd_vld),
    .rd_rdy (q_rd_rdy),
    .rd_dat (q_rd_dat)
  );

  // The FSM sees occupancy through a registered copy, keeping the FIFO count
  // compare off the decision path. The copy can only be stale-high on the
  // cycle after a pop, and the FSM never sits in IDLE on that cycle; the
  // live q_rd_vld term guards the pop anyway.
  assign head_take = (state == ST_IDLE) && head_vld_q && q_rd_vld;
  assign q_rd_rdy  = head_take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      head_vld_q  <= 1'b0;
      wait_cnt    <= '0;
      div_a       <= FP12_ZERO;
      div_b       <= FP12_ZERO;
      div_start   <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= FP12_ZERO;
      out_div0    <= 1'b0;
      out_timeout <= 1'b0;
    end else begin
      head_vld_q <= q_rd_vld;
      case (state)
        ST_IDLE: begin
          if (head_take) begin
            if (fp12_is_zero(head.b)) begin
              // Zero divisor is answered locally; the divider is never started.
              out_data  <= fp12_div0_result(head.a, head.b);
              out_div0  <= 1'b1;
              out_valid <= 1'b1;
              state     <= ST_OUTPUT;
            end else begin
              div_a     <= head.a;
              div_b     <= head.b;
              div_start <= 1'b1;
              state     <= ST_ISSUE;
            end
          end
        end

        ST_ISSUE: begin
          div_start <= 1'b0;
          wait_cnt  <= '0;
          state     <= ST_WAIT;
        end

        ST_WAIT: begin
          // div_done takes priority over a timeout landing on the same cycle.
          if (div_done) begin
            out_data  <= div_result;
            out_valid <= 1'b1;
            state     <= ST_OUTPUT;
          end else if (wait_cnt == WAIT_LAST) begin
            out_data    <= FP12_ZERO;
            out_timeout <= 1'b1;
            out_valid   <= 1'b1;
            state       <= ST_OUTPUT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_OUTPUT: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            out_div0    <= 1'b0;
            out_timeout <= 1'b0;
            state       <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // A divider request is a single-cycle pulse.
  assert property (@(posedge clk) disable iff (!rst_n) div_start |=> !div_start);

  // A presented result does not vanish before it is taken.
  assert property (@(posedge clk) disable iff (!rst_n)
                   (out_valid && !out_ready) |=> out_valid);

endmodule
